// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-port register file: default widths and
// FSM state encodings, reusable by any top that embeds the register file.
package reg_file_mp_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_NRD    = 2;

   localparam logic ST_IDLE_ENC  = 1'b0;
   localparam logic ST_CLEAR_ENC = 1'b1;

   typedef enum logic {
      ST_IDLE  = ST_IDLE_ENC,
      ST_CLEAR = ST_CLEAR_ENC
   } rf_state_e;

endpackage

// File: rtl/reg_file_rdport.sv
// One combinational read port: array lookup, write-through bypass and
// zero / not-ready masking.
module reg_file_rdport
   import reg_file_mp_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_REG = 1
) (
   input  logic [DATA_W-1:0] i_mem [2**ADDR_W],
   input  logic [ADDR_W-1:0] i_rd_addr,
   input  logic              i_ready,
   input  logic              i_wr_commit,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic [DATA_W-1:0] o_rd_data
);

   logic w_zero_hit;
   logic w_byp_hit;

   assign w_zero_hit = (ZERO_REG != 0) && (i_rd_addr == '0);
   assign w_byp_hit  = i_wr_commit && (i_wr_addr == i_rd_addr);

   // Masking has priority over bypass, bypass over the stored value
   always_comb begin
      o_rd_data = i_mem[i_rd_addr];
      if (w_byp_hit)
         o_rd_data = i_wr_data;
      if (!i_ready || w_zero_hit)
         o_rd_data = '0;
   end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: one write port, NRD asynchronous read ports,
// and a clear walk that zeroes one entry per cycle after reset or on request.
module reg_file_mp
   import reg_file_mp_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NRD      = DEF_NRD,
   parameter int ZERO_REG = 1
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic [NRD*ADDR_W-1:0] i_rd_addr,
   output logic [NRD*DATA_W-1:0] o_rd_data,
   input  logic                  i_wr_en,
   input  logic [ADDR_W-1:0]     i_wr_addr,
   input  logic [DATA_W-1:0]     i_wr_data,
   input  logic                  i_clear_req,
   output logic                  o_ready,
   output logic                  o_wr_ack
);

   localparam int                DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH-1);

   rf_state_e         r_state;
   rf_state_e         w_state_nxt;
   logic [ADDR_W-1:0] r_clr_cnt;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic              r_wr_ack;

   logic w_ready;
   logic w_wr_acc;
   logic w_wr_commit;
   logic w_clr_last;

   assign w_ready     = (r_state == ST_IDLE);
   // clear_req wins over a same-cycle write
   assign w_wr_acc    = i_wr_en && w_ready && !i_clear_req;
   // an address-0 write on a hardwired-zero file is neither stored nor acked
   assign w_wr_commit = w_wr_acc && !((ZERO_REG != 0) && (i_wr_addr == '0));
   assign w_clr_last  = (r_state == ST_CLEAR) && (r_clr_cnt == LAST);

   // State register; reset always (re)starts a clear walk
   always_ff @(posedge i_clock) begin
      if (i_reset) r_state <= ST_CLEAR;
      else         r_state <= w_state_nxt;
   end

   // Next state: clear_req seen only in IDLE, so a running clear never restarts
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (i_clear_req) w_state_nxt = ST_CLEAR;
         ST_CLEAR: if (w_clr_last)  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_CLEAR;
      endcase
   end

   // Clear address walks 0..DEPTH-1 and parks at 0 while idle
   always_ff @(posedge i_clock) begin
      if (i_reset)
         r_clr_cnt <= '0;
      else if (r_state == ST_CLEAR)
         r_clr_cnt <= w_clr_last ? '0 : r_clr_cnt + 1'b1;
   end

   // Storage: single write port shared by the clear walk and normal writes, no reset
   always_ff @(posedge i_clock) begin
      if (r_state == ST_CLEAR)
         r_mem[r_clr_cnt] <= '0;
      else if (w_wr_commit)
         r_mem[i_wr_addr] <= i_wr_data;
   end

   // Write acknowledge, one cycle after a committed write
   always_ff @(posedge i_clock) begin
      if (i_reset) r_wr_ack <= 1'b0;
      else         r_wr_ack <= w_wr_commit;
   end

   assign o_ready  = w_ready;
   assign o_wr_ack = r_wr_ack;

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      reg_file_rdport #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG)
      ) u_rdport (
         .i_mem       (r_mem),
         .i_rd_addr   (i_rd_addr[k*ADDR_W +: ADDR_W]),
         .i_ready     (w_ready),
         .i_wr_commit (w_wr_commit),
         .i_wr_addr   (i_wr_addr),
         .i_wr_data   (i_wr_data),
         .o_rd_data   (o_rd_data[k*DATA_W +: DATA_W])
      );
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: a default 2-port instance and a
// 4-port / 16-bit / 8-entry instance, checked against a behavioural model.
module tb_reg_file_mp;

   localparam int AW = 5, DW = 32, NA = 2, DEPTH_A = 32;
   localparam int BAW = 3, BDW = 16, NB = 4, DEPTH_B = 8;
   localparam int S_ARD = 0, S_ARDY = 2, S_AACK = 3;
   localparam int S_BRD = 4, S_BRDY = 8, S_BACK = 9;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // instance A (defaults)
   logic                a_rst, a_wr_en, a_clear_req, a_ready, a_wr_ack;
   logic [NA*AW-1:0]    a_rd_addr;
   logic [NA*DW-1:0]    a_rd_data;
   logic [AW-1:0]       a_wr_addr;
   logic [DW-1:0]       a_wr_data;

   // instance B (4 ports, 16 bit, 8 entries)
   logic                b_rst, b_wr_en, b_clear_req, b_ready, b_wr_ack;
   logic [NB*BAW-1:0]   b_rd_addr;
   logic [NB*BDW-1:0]   b_rd_data;
   logic [BAW-1:0]      b_wr_addr;
   logic [BDW-1:0]      b_wr_data;

   reg_file_mp u_dut_a (
      .i_clock(clk), .i_reset(a_rst), .i_rd_addr(a_rd_addr), .o_rd_data(a_rd_data),
      .i_wr_en(a_wr_en), .i_wr_addr(a_wr_addr), .i_wr_data(a_wr_data),
      .i_clear_req(a_clear_req), .o_ready(a_ready), .o_wr_ack(a_wr_ack));

   reg_file_mp #(.DATA_W(BDW), .ADDR_W(BAW), .NRD(NB)) u_dut_b (
      .i_clock(clk), .i_reset(b_rst), .i_rd_addr(b_rd_addr), .o_rd_data(b_rd_data),
      .i_wr_en(b_wr_en), .i_wr_addr(b_wr_addr), .i_wr_data(b_wr_data),
      .i_clear_req(b_clear_req), .o_ready(b_ready), .o_wr_ack(b_wr_ack));

   typedef struct {
      int          sel;
      int          due;
      logic [31:0] exp;
      string       tag;
   } exp_t;

   exp_t        sb_q[$];
   int          n_chk = 0;
   int          n_err = 0;
   logic [DW-1:0]  mdl_a [DEPTH_A];
   logic [BDW-1:0] mdl_b [DEPTH_B];
   int          a_left = 0;
   int          b_left = 0;

   function automatic logic [31:0] obs(int sel);
      case (sel)
         0:       return a_rd_data[0  +: DW];
         1:       return a_rd_data[DW +: DW];
         2:       return {31'b0, a_ready};
         3:       return {31'b0, a_wr_ack};
         4, 5, 6, 7: return {16'b0, b_rd_data[(sel-S_BRD)*BDW +: BDW]};
         8:       return {31'b0, b_ready};
         default: return {31'b0, b_wr_ack};
      endcase
   endfunction

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   task automatic sb_push(int sel, int lag, logic [31:0] exp, string tag);
      exp_t e;
      e.sel = sel; e.due = cyc + lag; e.exp = exp; e.tag = tag;
      sb_q.push_back(e);
   endtask

   // compare every entry due this cycle, mid-cycle (away from the rising edge)
   task automatic sample();
      exp_t keep[$];
      #3;
      while (sb_q.size() > 0) begin
         exp_t e = sb_q.pop_front();
         if (e.due == cyc) check(e.tag, obs(e.sel), e.exp);
         else if (e.due > cyc) keep.push_back(e);
         else begin
            n_err++;
            $display("FAIL %s: expectation for cyc %0d never sampled", e.tag, e.due);
         end
      end
      sb_q = keep;
   endtask

   task automatic tick();
      sample();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic a_reset_cycle();
      a_rst = 1'b1; a_wr_en = 1'b0; a_clear_req = 1'b0;
      sb_push(S_AACK, 1, 32'd0, "a_rst_ack");
      tick();
      a_rst = 1'b0;
      a_left = DEPTH_A;
      foreach (mdl_a[i]) mdl_a[i] = '0;
   endtask

   task automatic a_cycle(bit we, int wa, logic [DW-1:0] wd, bit clr, int ra0, int ra1);
      bit rdy = (a_left == 0);
      bit acc = we && rdy && !clr;
      int ra[2];
      ra[0] = ra0; ra[1] = ra1;
      a_wr_en = we; a_wr_addr = AW'(wa); a_wr_data = wd; a_clear_req = clr;
      a_rd_addr = {AW'(ra1), AW'(ra0)};
      sb_push(S_ARDY, 0, {31'b0, rdy}, "a_ready");
      for (int k = 0; k < NA; k++) begin
         logic [DW-1:0] e;
         if (!rdy || ra[k] == 0)        e = '0;
         else if (acc && wa == ra[k])   e = wd;
         else                           e = mdl_a[ra[k]];
         sb_push(S_ARD + k, 0, e, $sformatf("a_rd%0d[%0d]", k, ra[k]));
      end
      sb_push(S_AACK, 1, {31'b0, acc && wa != 0}, "a_ack");
      tick();
      if (acc && wa != 0) mdl_a[wa] = wd;
      if (rdy && clr) begin
         a_left = DEPTH_A;
         foreach (mdl_a[i]) mdl_a[i] = '0;
      end else if (!rdy) a_left--;
   endtask

   task automatic b_reset_cycle();
      b_rst = 1'b1; b_wr_en = 1'b0; b_clear_req = 1'b0;
      sb_push(S_BACK, 1, 32'd0, "b_rst_ack");
      tick();
      b_rst = 1'b0;
      b_left = DEPTH_B;
      foreach (mdl_b[i]) mdl_b[i] = '0;
   endtask

   task automatic b_cycle(bit we, int wa, logic [BDW-1:0] wd, int r0, int r1, int r2, int r3);
      bit rdy = (b_left == 0);
      bit acc = we && rdy;
      int ra[4];
      ra[0] = r0; ra[1] = r1; ra[2] = r2; ra[3] = r3;
      b_wr_en = we; b_wr_addr = BAW'(wa); b_wr_data = wd; b_clear_req = 1'b0;
      b_rd_addr = {BAW'(r3), BAW'(r2), BAW'(r1), BAW'(r0)};
      sb_push(S_BRDY, 0, {31'b0, rdy}, "b_ready");
      for (int k = 0; k < NB; k++) begin
         logic [BDW-1:0] e;
         if (!rdy || ra[k] == 0)        e = '0;
         else if (acc && wa == ra[k])   e = wd;
         else                           e = mdl_b[ra[k]];
         sb_push(S_BRD + k, 0, {16'b0, e}, $sformatf("b_rd%0d[%0d]", k, ra[k]));
      end
      sb_push(S_BACK, 1, {31'b0, acc && wa != 0}, "b_ack");
      tick();
      if (acc && wa != 0) mdl_b[wa] = wd;
      if (!rdy) b_left--;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      a_rst = 1'b1; a_wr_en = 1'b0; a_clear_req = 1'b0; a_rd_addr = '0;
      a_wr_addr = '0; a_wr_data = '0;
      b_rst = 1'b1; b_wr_en = 1'b0; b_clear_req = 1'b0; b_rd_addr = '0;
      b_wr_addr = '0; b_wr_data = '0;

      // one-cycle reset, then 32 clear cycles with ready low and reads masked
      a_reset_cycle();
      for (int c = 0; c <= DEPTH_A; c++) a_cycle(0, 0, '0, 0, c % DEPTH_A, DEPTH_A-1 - c % DEPTH_A);
      for (int i = 0; i < DEPTH_A; i++) a_cycle(0, 0, '0, 0, i, DEPTH_A-1-i);

      // bypass on both ports, then stored value
      a_cycle(1, 7, 32'hDEADBEEF, 0, 7, 7);
      a_cycle(0, 0, '0, 0, 7, 7);

      // hardwired zero register
      a_cycle(1, 0, 32'h12345678, 0, 0, 0);
      a_cycle(0, 0, '0, 0, 0, 0);

      // fill 1..31 with own index, port0 bypass, port1 previous entry
      for (int i = 1; i < DEPTH_A; i++) a_cycle(1, i, DW'(i), 0, i, i-1);
      for (int i = 0; i < DEPTH_A; i++) a_cycle(0, 0, '0, 0, i, (i+5) % DEPTH_A);

      // clear request with a same-cycle write (dropped, no bypass)
      a_cycle(1, 5, 32'h000000AA, 1, 5, 6);
      // writes during the clear are dropped; repeated clear_req ignored
      for (int c = 0; c <= DEPTH_A; c++) a_cycle(1, 3, 32'hFF, c == 10, 3, c % DEPTH_A);
      for (int i = 0; i < DEPTH_A; i++) a_cycle(0, 0, '0, 0, i, DEPTH_A-1-i);

      // reset in the middle of a clear restarts the walk
      for (int i = 1; i < DEPTH_A; i++) a_cycle(1, i, ~DW'(i), 0, i, 0);
      a_cycle(0, 0, '0, 1, 1, 2);
      for (int c = 0; c < 10; c++) a_cycle(0, 0, '0, 0, c, 31);
      a_reset_cycle();
      for (int c = 0; c <= DEPTH_A; c++) a_cycle(0, 0, '0, 0, c % DEPTH_A, 1);
      for (int i = 0; i < DEPTH_A; i++) a_cycle(0, 0, '0, 0, i, (i+9) % DEPTH_A);

      // 4-port, 8-entry instance
      b_reset_cycle();
      for (int c = 0; c <= DEPTH_B; c++) b_cycle(0, 0, '0, c % DEPTH_B, 1, 2, 3);
      for (int i = 1; i < DEPTH_B; i++) b_cycle(1, i, BDW'(i * 16'h1111), i, i-1, 0, 7);
      b_cycle(0, 0, '0, 1, 2, 3, 4);
      b_cycle(1, 5, 16'hBEEF, 5, 5, 0, 1);
      b_cycle(0, 0, '0, 5, 4, 3, 2);

      a_wr_en = 1'b0; b_wr_en = 1'b0;
      tick();
      if (sb_q.size() != 0) begin
         n_err += sb_q.size();
         $display("FAIL scoreboard: %0d expectations left unchecked", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
